// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, keyboard command bytes and the us-to-cycles macro.
// Also used by the keyboard receiver that shares the PS/2 pads.
`define PS2_US_TO_CYCLES(us, hz) ((us) * ((hz) / 1000000))

package ps2_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_ACK       = 3'd5;
    localparam logic [2:0] S_WAIT_IDLE = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = S_IDLE,
        ST_INHIBIT   = S_INHIBIT,
        ST_REQ       = S_REQ,
        ST_SHIFT     = S_SHIFT,
        ST_STOP      = S_STOP,
        ST_ACK       = S_ACK,
        ST_WAIT_IDLE = S_WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus glitch filter for one PS/2 pad; o_fall pulses for one cycle
// in the same cycle the filtered level changes from 1 to 0.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync2;
                r_fall  <= r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ack check.
// Optional macro PS2_TX_RETRY_EN: retry NACK/timeout up to 2 times before reporting.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int INHIBIT_US   = 120,
    parameter int START_TMO_US = 15000,
    parameter int PKT_TMO_US   = 2000,
    parameter int FILTER_LEN   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    // Request handshake: a byte is taken on any cycle where i_tx_valid & o_tx_ready.
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output ps2_state_t o_state
);

    localparam int INH_CYC   = `PS2_US_TO_CYCLES(INHIBIT_US, CLK_HZ);
    localparam int START_CYC = `PS2_US_TO_CYCLES(START_TMO_US, CLK_HZ);
    localparam int PKT_CYC   = `PS2_US_TO_CYCLES(PKT_TMO_US, CLK_HZ);
    localparam int TMO_MAX   = (START_CYC > PKT_CYC) ? START_CYC : PKT_CYC;
    localparam int TW        = $clog2(TMO_MAX + 1);
    localparam int IW        = $clog2(INH_CYC + 1);
    localparam logic [TW-1:0] START_LIM = TW'(START_CYC);
    localparam logic [TW-1:0] PKT_LIM   = TW'(PKT_CYC);
    localparam logic [IW-1:0] INH_LAST  = IW'(INH_CYC - 1);
    localparam logic [IW-1:0] INH_PRE   = IW'(INH_CYC - 2);

    ps2_state_t    r_state, w_state_nxt;
    logic [7:0]    r_data, w_data_nxt;
    logic          r_parity, w_parity_nxt;
    logic [3:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt, w_tmo_inc;
    logic [IW-1:0] r_inh, w_inh_nxt;
    logic          r_clk_oe, w_clk_oe_nxt;
    logic          r_data_oe, w_data_oe_nxt;
    logic          r_done, w_done_nxt;
    logic          r_err, w_err_nxt;
    logic          r_nack, w_nack_nxt;
    logic          w_finish, w_finish_err;
    logic          w_clk_level, w_clk_fall, w_data_level, w_data_fall_unused;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]    r_retry, w_retry_nxt;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_ps2_clk),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_ps2_data),
        .o_level (w_data_level),
        .o_fall  (w_data_fall_unused)
    );

    // Saturating so a stuck device can never wrap the counter back below its limit.
    assign w_tmo_inc = (&r_tmo) ? r_tmo : r_tmo + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_parity_nxt  = r_parity;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tmo_nxt     = r_tmo;
        w_inh_nxt     = r_inh;
        w_clk_oe_nxt  = r_clk_oe;
        w_data_oe_nxt = r_data_oe;
        w_nack_nxt    = r_nack;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_finish      = 1'b0;
        w_finish_err  = 1'b0;
`ifdef PS2_TX_RETRY_EN
        w_retry_nxt   = r_retry;
`endif
        case (r_state)
            ST_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                if (i_tx_valid) begin
                    w_state_nxt   = ST_INHIBIT;
                    w_data_nxt    = i_tx_data;
                    w_parity_nxt  = ~^i_tx_data;
                    w_bit_cnt_nxt = 4'd0;
                    w_inh_nxt     = '0;
                    w_clk_oe_nxt  = 1'b1;
`ifdef PS2_TX_RETRY_EN
                    w_retry_nxt   = 2'd0;
`endif
                end
            end
            ST_INHIBIT: begin
                w_inh_nxt = r_inh + 1'b1;
                if (r_inh == INH_PRE) w_data_oe_nxt = 1'b1;
                if (r_inh == INH_LAST) begin
                    w_state_nxt   = ST_REQ;
                    w_clk_oe_nxt  = 1'b0;
                    w_data_oe_nxt = 1'b1;
                    w_tmo_nxt     = '0;
                end
            end
            ST_REQ: begin
                w_tmo_nxt = w_tmo_inc;
                if (w_clk_fall) begin
                    w_state_nxt   = ST_SHIFT;
                    w_tmo_nxt     = '0;
                    w_bit_cnt_nxt = 4'd1;
                    w_data_oe_nxt = ~r_data[0];
                end else if (r_tmo >= START_LIM) begin
                    w_finish     = 1'b1;
                    w_finish_err = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_tmo_nxt = w_tmo_inc;
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd8) begin
                        w_data_oe_nxt = ~r_parity;
                        w_state_nxt   = ST_STOP;
                    end else begin
                        w_data_oe_nxt = ~r_data[r_bit_cnt[2:0]];
                    end
                end else if (r_tmo >= PKT_LIM) begin
                    w_finish     = 1'b1;
                    w_finish_err = 1'b1;
                end
            end
            ST_STOP: begin
                w_tmo_nxt = w_tmo_inc;
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_data_oe_nxt = 1'b0;
                    w_state_nxt   = ST_ACK;
                end else if (r_tmo >= PKT_LIM) begin
                    w_finish     = 1'b1;
                    w_finish_err = 1'b1;
                end
            end
            ST_ACK: begin
                w_tmo_nxt = w_tmo_inc;
                if (w_clk_fall) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_nack_nxt    = w_data_level;
                    w_state_nxt   = ST_WAIT_IDLE;
                end else if (r_tmo >= PKT_LIM) begin
                    w_finish     = 1'b1;
                    w_finish_err = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clk_level && w_data_level) begin
                    w_finish     = 1'b1;
                    w_finish_err = r_nack;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_finish) begin
            w_state_nxt   = ST_IDLE;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_done_nxt    = 1'b1;
            w_err_nxt     = w_finish_err;
`ifdef PS2_TX_RETRY_EN
            if (w_finish_err && (r_retry != 2'd2)) begin
                w_state_nxt   = ST_INHIBIT;
                w_clk_oe_nxt  = 1'b1;
                w_inh_nxt     = '0;
                w_bit_cnt_nxt = 4'd0;
                w_done_nxt    = 1'b0;
                w_err_nxt     = 1'b0;
                w_retry_nxt   = r_retry + 2'd1;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_tmo     <= '0;
            r_inh     <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_parity  <= w_parity_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tmo     <= w_tmo_nxt;
            r_inh     <= w_inh_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_nack    <= w_nack_nxt;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_retry <= 2'd0;
        else          r_retry <= w_retry_nxt;
    end
`endif

    assign o_tx_ready    = (r_state == ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;
    assign o_state       = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device, frame model and directed/random transfers.
// Honours PS2_TX_RETRY_EN when counting attempts.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int HALF = 40;  // 12.5 kHz device clock at a 1 MHz system clock
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
    ps2_state_t state;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_pad, ps2_data_pad;

    assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ(1_000_000), .INHIBIT_US(120), .START_TMO_US(15000),
        .PKT_TMO_US(2000), .FILTER_LEN(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_busy(busy), .o_done(done), .o_err(err),
        .i_ps2_clk(ps2_clk_pad), .i_ps2_data(ps2_data_pad),
        .o_ps2_clk_oe(ps2_clk_oe), .o_ps2_data_oe(ps2_data_oe), .o_state(state)
    );

    int checks = 0;
    int failures = 0;
    int inh_pulses = 0;
    int inh_len = 0;
    int last_inh_len = 0;
    int done_cnt = 0;
    logic last_inh_data_oe = 1'b0;
    logic prev_clk_oe = 1'b0;
    logic prev_data_oe = 1'b0;
    logic [10:0] exp_q[$];

    // Line monitor: inhibit pulse count/length and done pulses.
    always @(negedge clk) begin
        if (ps2_clk_oe && !prev_clk_oe) begin
            inh_pulses = inh_pulses + 1;
            inh_len = 1;
        end else if (ps2_clk_oe) begin
            inh_len = inh_len + 1;
        end
        if (!ps2_clk_oe && prev_clk_oe) begin
            last_inh_len = inh_len;
            last_inh_data_oe = prev_data_oe;
        end
        if (done) done_cnt = done_cnt + 1;
        prev_clk_oe = ps2_clk_oe;
        prev_data_oe = ps2_data_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: {stop=1, odd parity, data}, data sent LSB first.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0), d};
    endfunction

    task automatic send(input logic [7:0] d, input bit hold);
        @(negedge clk);
        tx_data = d;
        tx_valid = 1'b1;
        exp_q.push_back(frame_of(d));
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        chk("accept_ready_low", {31'b0, tx_ready}, 32'd0);
        chk("accept_busy_high", {31'b0, busy}, 32'd1);
    endtask

    // Device side: wait for request-to-send, clock 11 falls, sample data before each rise.
    task automatic dev_frame(input bit ack, input int stop_after, input bit glitch,
                             output logic [10:0] cap, output bit seen);
        int t = 0;
        cap = '0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        seen = ps2_data_oe && !ps2_clk_oe;
        if (!seen) return;
        repeat (HALF) @(negedge clk);
        for (int n = 1; n <= 11; n++) begin
            dev_clk_low = 1'b1;
            if (n == stop_after) return;
            repeat (HALF) @(negedge clk);
            if (n <= 10) cap[n-1] = ps2_data_pad;
            dev_clk_low = 1'b0;
            if (n == 11) break;
            repeat (HALF / 2) @(negedge clk);
            if (n == 10 && ack) dev_data_low = 1'b1;
            if (glitch && n >= 2 && n <= 8) begin
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF - HALF / 2 - 3) @(negedge clk);
            end else begin
                repeat (HALF - HALF / 2) @(negedge clk);
            end
        end
        repeat (10) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output logic e);
        got = 0;
        e = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                e = err;
                tx_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch,
                             input string tag, output logic [10:0] cap);
        int d0 = done_cnt;
        int i0 = inh_pulses;
        bit seen, got;
        logic e;
        send(d, 1'b0);
        dev_frame(ack, 0, glitch, cap, seen);
        chk({tag, "_req_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, "_frame"}, {21'b0, cap}, {21'b0, exp_q.pop_front()});
        wait_done(3000, got, e);
        chk({tag, "_done_seen"}, {31'b0, got}, 32'd1);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, ~ack});
        repeat (2) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt - d0, 32'd1);
        chk({tag, "_inhibits"}, inh_pulses - i0, 32'd1);
        chk({tag, "_idle_ready"}, {31'b0, tx_ready}, 32'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] cap;
        logic [7:0] d;
        bit seen, got;
        logic e;
        int d0, i0;

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        chk("rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Set-LEDs command: bits 1,0,1,1,0,1,1,1 then parity 1.
        run_frame(PS2_CMD_LEDS, 1'b1, 1'b0, "ed", cap);
        chk("ed_bits_parity", {23'b0, cap[8:0]}, 32'h1ED);

        // Enable command: parity 0; clock held low 120 cycles with data low in the last one.
        run_frame(PS2_CMD_ENABLE, 1'b1, 1'b0, "f4", cap);
        chk("f4_parity", {31'b0, cap[8]}, 32'd0);
        chk("f4_inhibit_len", last_inh_len, 32'd120);
        chk("f4_inhibit_start_bit", {31'b0, last_inh_data_oe}, 32'd1);

        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            run_frame(d, 1'b1, 1'b0, "rnd", cap);
        end

        d = 8'($urandom_range(0, 255));
        run_frame(d, 1'b1, 1'b1, "glitch", cap);

        // NACK: data left high at fall 11.
        d0 = done_cnt; i0 = inh_pulses;
        send(8'($urandom_range(0, 255)), 1'b0);
        for (int a = 0; a < ATTEMPTS; a++) begin
            dev_frame(1'b0, 0, 1'b0, cap, seen);
            chk("nack_req_seen", {31'b0, seen}, 32'd1);
            chk("nack_frame", {21'b0, cap}, {21'b0, exp_q[0]});
        end
        void'(exp_q.pop_front());
        wait_done(3000, got, e);
        chk("nack_done_seen", {31'b0, got}, 32'd1);
        chk("nack_err", {31'b0, e}, 32'd1);
        repeat (2) @(negedge clk);
        chk("nack_inhibits", inh_pulses - i0, ATTEMPTS);
        chk("nack_done_count", done_cnt - d0, 32'd1);

        // tx_valid held high and tx_data changed while busy: exactly one original frame.
        d0 = done_cnt; i0 = inh_pulses;
        send(8'h3C, 1'b1);
        tx_data = 8'h00;
        dev_frame(1'b1, 0, 1'b0, cap, seen);
        chk("hold_frame", {21'b0, cap}, {21'b0, exp_q.pop_front()});
        wait_done(3000, got, e);
        chk("hold_done_seen", {31'b0, got}, 32'd1);
        repeat (4) @(negedge clk);
        chk("hold_inhibits", inh_pulses - i0, 32'd1);
        chk("hold_done_count", done_cnt - d0, 32'd1);
        chk("hold_state_idle", 32'(state), 32'(ST_IDLE));

        // Reset at fall 5: lines released next cycle, no done pulse.
        send(8'hA7, 1'b0);
        d0 = done_cnt;
        dev_frame(1'b1, 5, 1'b0, cap, seen);
        chk("rst5_req_seen", {31'b0, seen}, 32'd1);
        repeat (14) @(negedge clk);
        chk("rst5_in_shift", 32'(state), 32'(ST_SHIFT));
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst5_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        chk("rst5_data_oe", {31'b0, ps2_data_oe}, 32'd0);
        chk("rst5_tx_ready", {31'b0, tx_ready}, 32'd1);
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        repeat (20) @(negedge clk);
        chk("rst5_no_done", done_cnt - d0, 32'd0);
        run_frame(PS2_CMD_RESET, 1'b1, 1'b0, "ff", cap);

        // Silent device: start timeout, both lines released, err reported.
        d0 = done_cnt; i0 = inh_pulses;
        send(8'h11, 1'b0);
        wait_done(60000, got, e);
        chk("tmo_done_seen", {31'b0, got}, 32'd1);
        chk("tmo_err", {31'b0, e}, 32'd1);
        chk("tmo_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        chk("tmo_data_oe", {31'b0, ps2_data_oe}, 32'd0);
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        chk("tmo_inhibits", inh_pulses - i0, ATTEMPTS);
        chk("tmo_done_count", done_cnt - d0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
